stream_downsizer: RTL



---
 rtl/stream_downsizer_pkg.sv | 36 +++
 rtl/stream_downsizer.sv | 90 +++++++++
 2 files changed

// File: rtl/stream_downsizer_pkg.sv
// Shared helpers for the stream width converters: ratio/byte-count
// derivations, keep-mask to last-sub-word index, and prefix-mask test.
package stream_downsizer_pkg;

   // Widest keep mask the helper functions accept (1024-bit data path).
   localparam int KEEP_MAX_W = 128;

   // Number of bytes in a data word of the given bit width.
   function automatic int calc_out_bytes(input int outWidth);
      return outWidth / 8;
   endfunction

   // Number of narrow sub-words carried by one wide beat.
   function automatic int calc_ratio(input int inWidth, input int outWidth);
      return inWidth / outWidth;
   endfunction

   // Index of the last narrow sub-word that carries any valid byte.
   // An all-zero keep still yields index 0 so a bare tlast can be emitted.
   function automatic int keep_to_last_idx(input logic [KEEP_MAX_W-1:0] keep,
                                           input int outBytes);
      int pop;
      pop = 0;
      for (int b = 0; b < KEEP_MAX_W; b++) begin
         if (keep[b]) pop++;
      end
      if (pop == 0) return 0;
      return ((pop + outBytes - 1) / outBytes) - 1;
   endfunction

   // True when the ones in keep are contiguous from bit 0 (or keep is zero).
   function automatic logic is_prefix_mask(input logic [KEEP_MAX_W-1:0] keep);
      return ((keep & (keep + KEEP_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Width down-converter: splits each wide stream beat into narrow sub-words,
// skipping empty trailing sub-words and keeping tlast on the final one.
module stream_downsizer
   import stream_downsizer_pkg::*;
#(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 64
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [IN_WIDTH-1:0]    i_data_tdata,
   input  logic [IN_WIDTH/8-1:0]  i_data_tkeep,
   input  logic                   i_data_tlast,
   input  logic                   i_data_tvalid,
   output logic                   i_data_tready,
   output logic [OUT_WIDTH-1:0]   o_data_tdata,
   output logic [OUT_WIDTH/8-1:0] o_data_tkeep,
   output logic                   o_data_tlast,
   output logic                   o_data_tvalid,
   input  logic                   o_data_tready
);

   localparam int IN_BYTES  = IN_WIDTH / 8;
   localparam int OUT_BYTES = calc_out_bytes(OUT_WIDTH);
   localparam int RATIO     = calc_ratio(IN_WIDTH, OUT_WIDTH);
   localparam int IDX_W     = (RATIO < 2) ? 1 : $clog2(RATIO);

   // Reject parameter sets the sub-word slicing cannot support.
   if ((RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0) || ((OUT_WIDTH % 8) != 0) ||
       (IN_BYTES > KEEP_MAX_W)) begin : g_paramCheck
      $error("stream_downsizer: illegal IN_WIDTH/OUT_WIDTH combination");
   end

   logic [IN_WIDTH-1:0] r_holdData;
   logic [IN_BYTES-1:0] r_holdKeep;
   logic                r_holdLast;
   logic                r_holdValid;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    r_lidx;

   logic                w_outFire;
   logic                w_final;
   logic                w_inFire;
   logic                w_dropBeat;
   logic [IDX_W-1:0]    w_nextLidx;

   // Handshake decode and output slicing, driven from the hold registers only.
   always_comb begin
      w_outFire     = r_holdValid && o_data_tready;
      w_final       = (r_idx == r_lidx);
      i_data_tready = !r_holdValid || (w_outFire && w_final);
      w_inFire      = i_data_tvalid && i_data_tready;
      w_dropBeat    = (i_data_tkeep == '0) && !i_data_tlast;
      w_nextLidx    = IDX_W'(keep_to_last_idx(KEEP_MAX_W'(i_data_tkeep), OUT_BYTES));
      o_data_tvalid = r_holdValid;
      o_data_tdata  = r_holdData[32'(r_idx) * OUT_WIDTH +: OUT_WIDTH];
      o_data_tkeep  = r_holdKeep[32'(r_idx) * OUT_BYTES +: OUT_BYTES];
      o_data_tlast  = r_holdLast && w_final;
   end

   // Hold register and sub-word index: reload on input accept, step on output accept.
   // Data/keep are left out of reset; they are qualified by r_holdValid.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_holdValid <= 1'b0;
         r_holdLast  <= 1'b0;
         r_idx       <= '0;
         r_lidx      <= '0;
      end else if (w_inFire) begin
         r_holdData  <= i_data_tdata;
         r_holdKeep  <= i_data_tkeep;
         r_holdLast  <= i_data_tlast;
         r_holdValid <= !w_dropBeat;
         r_idx       <= '0;
         r_lidx      <= w_nextLidx;
      end else if (w_outFire) begin
         if (!w_final) begin
            r_idx <= r_idx + IDX_W'(1);
         end else begin
            r_holdValid <= 1'b0;
         end
      end
   end

   // Upstream must present prefix keep masks; flag anything else in simulation.
   a_prefixKeep: assert property (@(posedge aclk) disable iff (!aresetn)
      i_data_tvalid |-> is_prefix_mask(KEEP_MAX_W'(i_data_tkeep)))
      else $error("stream_downsizer: non-prefix tkeep on input");

endmodule
